// File: rtl/scan_pkg.sv
// Shared constants and helpers for the mux select scanner: mode encoding,
// blank digit pattern and select-to-digit-enable decode.
package scan_pkg;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    localparam logic [3:0] AN_BLANK = 4'b1111;

    // Active-low one-hot digit enable for a 2-bit select value.
    function automatic logic [3:0] sel_to_an(input logic [1:0] sel);
        logic [3:0] onehot;
        onehot = 4'b0001 << sel;
        return ~onehot;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-sample debouncer and
// rising-edge detector producing a single-cycle pulse per debounced press.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          prev_q,  prev_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = level_q;
        level_d = level_q;
        cnt_d   = '0;
        // The level only moves after DB_CYCLES consecutive disagreeing samples;
        // any agreeing sample restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/mux_sel_scan.sv
// Select-bus generator for a 4:1 mux with matching active-low digit enables;
// advances from a prescaler (auto) or from debounced button presses (manual).
module mux_sel_scan
    import scan_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       btn_step,
    output logic [1:0] S,
    output logic [3:0] AN,
    output logic       step
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          btn_level;
    logic          btn_rise;
    logic          press;
    logic          adv;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    s_q,     s_d;
    logic [3:0]    an_q,    an_d;
    logic          step_q,  step_d;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_step),
        .level (btn_level),
        .rise  (btn_rise)
    );

    assign press = btn_rise & btn_level;

    // Mode picks exactly one advance source, so at most one increment per cycle.
    always_comb begin
        adv     = 1'b0;
        presc_d = presc_q;
        if (en) begin
            if (mode == MODE_MANUAL) begin
                presc_d = '0;
                adv     = press;
            end else if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                adv     = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        s_d    = adv ? s_q + 2'd1 : s_q;
        step_d = adv;
        // Decode from the next select so AN and S change on the same edge.
        an_d   = en ? sel_to_an(s_d) : AN_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            s_q     <= 2'b00;
            an_q    <= AN_BLANK;
            step_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            s_q     <= s_d;
            an_q    <= an_d;
            step_q  <= step_d;
        end
    end

    assign S    = s_q;
    assign AN   = an_q;
    assign step = step_q;

endmodule

// File: tb/tb_mux_sel_scan.sv
// Bench for mux_sel_scan: three instances (TICK_DIV 4, 8, 1; DB_CYCLES 3)
// share stimulus; each vector checks the instance it targets.
module tb_mux_sel_scan;

    typedef struct {
        int         tst;
        logic [1:0] which;
        logic       rst;
        logic       en;
        logic       mode;
        logic       btn;
        logic [1:0] s;
        logic [3:0] an;
        logic       step;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       btn_step;

    logic [1:0] s_a, s_b, s_c;
    logic [3:0] an_a, an_b, an_c;
    logic       step_a, step_b, step_c;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];
    int         n_vec;
    int         n_err;

    mux_sel_scan #(.TICK_DIV(4), .DB_CYCLES(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .btn_step(btn_step),
        .S(s_a), .AN(an_a), .step(step_a)
    );

    mux_sel_scan #(.TICK_DIV(8), .DB_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .btn_step(btn_step),
        .S(s_b), .AN(an_b), .step(step_b)
    );

    mux_sel_scan #(.TICK_DIV(1), .DB_CYCLES(3)) dut_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .btn_step(btn_step),
        .S(s_c), .AN(an_c), .step(step_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] an_of(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic void add(input int tst, input logic [1:0] which,
                                input logic r, input logic e, input logic m,
                                input logic b, input logic [1:0] s,
                                input logic [3:0] an, input logic st);
        vec_t v;
        v.tst = tst; v.which = which; v.rst = r; v.en = e; v.mode = m; v.btn = b;
        v.s = s; v.an = an; v.step = st;
        vecs.push_back(v);
    endfunction

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        logic [6:0] got;
        logic [6:0] exp;
        rst      = v.rst;
        en       = v.en;
        mode     = v.mode;
        btn_step = v.btn;
        exp_q.push_back({v.s, v.an, v.step});
        @(posedge clk);
        #1;
        case (v.which)
            2'd0:    got = {s_a, an_a, step_a};
            2'd1:    got = {s_b, an_b, step_b};
            default: got = {s_c, an_c, step_c};
        endcase
        exp = exp_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL t%0d vec%0d dut%0d: S/AN/step got %b/%b/%b want %b/%b/%b",
                     v.tst, n_vec, v.which, got[6:5], got[4:1], got[0],
                     exp[6:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic hand(input int tst, input logic [1:0] which, input logic r,
                        input logic e, input logic m, input logic b,
                        input logic [1:0] s, input logic [3:0] an, input logic st);
        vec_t v;
        v.tst = tst; v.which = which; v.rst = r; v.en = e; v.mode = m; v.btn = b;
        v.s = s; v.an = an; v.step = st;
        apply(v);
    endtask

    initial begin
        logic [1:0] s;
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        en       = 1'b1;
        mode     = 1'b0;
        btn_step = 1'b0;

        // 1: reset then auto scan, TICK_DIV=4
        add(1, 0, 1, 1, 0, 0, 2'd0, 4'b1111, 0);
        for (int c = 0; c < 16; c++) begin
            s = 2'((c + 1) / 4);
            add(1, 0, 0, 1, 0, 0, s, an_of(s), (c % 4) == 3);
        end

        // 2: freeze with en=0 at S=2, prescaler=1
        add(2, 0, 1, 1, 0, 0, 2'd0, 4'b1111, 0);
        for (int c = 0; c < 9; c++) begin
            s = 2'((c + 1) / 4);
            add(2, 0, 0, 1, 0, 0, s, an_of(s), (c % 4) == 3);
        end
        for (int c = 0; c < 3; c++) add(2, 0, 0, 0, 0, 0, 2'd2, 4'b1111, 0);
        add(2, 0, 0, 1, 0, 0, 2'd2, 4'b1011, 0);
        add(2, 0, 0, 1, 0, 0, 2'd2, 4'b1011, 0);
        add(2, 0, 0, 1, 0, 0, 2'd3, 4'b0111, 1);
        add(2, 0, 0, 1, 0, 0, 2'd3, 4'b0111, 0);

        // 5: TICK_DIV=1 advances every enabled cycle
        add(5, 2, 1, 1, 0, 0, 2'd0, 4'b1111, 0);
        for (int c = 0; c < 5; c++) begin
            s = 2'((c + 1) % 4);
            add(5, 2, 0, 1, 0, 0, s, an_of(s), 1);
        end

        // 4: auto ignores button, switch to manual with button held, back to auto
        add(4, 1, 1, 1, 0, 0, 2'd0, 4'b1111, 0);
        for (int c = 0; c < 16; c++) begin
            s = 2'((c + 1) / 8);
            add(4, 1, 0, 1, 0, (c >= 2 && c <= 7), s, an_of(s), (c % 8) == 7);
        end
        for (int c = 16; c < 23; c++) add(4, 1, 0, 1, 0, 1, 2'd2, 4'b1011, 0);
        for (int c = 23; c < 29; c++) add(4, 1, 0, 1, 1, 1, 2'd2, 4'b1011, 0);
        for (int a = 0; a < 8; a++) begin
            s = (a == 7) ? 2'd3 : 2'd2;
            add(4, 1, 0, 1, 0, 1, s, an_of(s), a == 7);
        end

        foreach (vecs[i]) apply(vecs[i]);

        // 3: manual debounce through bounce, single step on stable press
        hand(3, 0, 1, 1, 1, 0, 2'd0, 4'b1111, 0);
        for (int t = 0; t < 10; t++) hand(3, 0, 0, 1, 1, (t % 2) == 0, 2'd0, 4'b1110, 0);
        for (int t = 10; t < 15; t++) hand(3, 0, 0, 1, 1, 1, 2'd0, 4'b1110, 0);
        hand(3, 0, 0, 1, 1, 1, 2'd1, 4'b1101, 1);
        for (int t = 16; t < 20; t++) hand(3, 0, 0, 1, 1, 1, 2'd1, 4'b1101, 0);
        for (int t = 20; t < 32; t++) hand(3, 0, 0, 1, 1, 0, 2'd1, 4'b1101, 0);

        // 6: reset mid-scan at S=3, prescaler=2
        hand(6, 0, 1, 1, 0, 0, 2'd0, 4'b1111, 0);
        for (int c = 0; c < 14; c++) begin
            s = 2'((c + 1) / 4);
            hand(6, 0, 0, 1, 0, 0, s, an_of(s), (c % 4) == 3);
        end
        hand(6, 0, 1, 1, 0, 0, 2'd0, 4'b1111, 0);
        for (int c = 0; c < 3; c++) hand(6, 0, 0, 1, 0, 0, 2'd0, 4'b1110, 0);
        hand(6, 0, 0, 1, 0, 0, 2'd1, 4'b1101, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
